// File: rtl/instr_encoder_pkg.sv
// Shared types, constants and the immediate legality check for the instruction encoder.
// The field bundle travels from the input port through stage 1 into the packer.
package instr_encoder_pkg;

   localparam int DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } imm_fmt_e;

   localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

   localparam int signed IMM_I_MIN = -2048;
   localparam int signed IMM_I_MAX = 2047;
   localparam int signed IMM_B_MIN = -4096;
   localparam int signed IMM_B_MAX = 4094;
   localparam int signed IMM_J_MIN = -1048576;
   localparam int signed IMM_J_MAX = 1048574;

   typedef struct packed {
      logic [2:0]            fmt;
      logic [6:0]            opcode;
      logic [4:0]            rd;
      logic [4:0]            rs1;
      logic [4:0]            rs2;
      logic [2:0]            funct3;
      logic [6:0]            funct7;
      logic [DATA_WIDTH-1:0] imm;
   } instr_fields_t;

   // B/J immediates are byte offsets whose bit 0 is not encodable, hence the alignment term.
   function automatic logic imm_check_err(input logic [2:0] fmt,
                                          input logic [DATA_WIDTH-1:0] imm);
      logic signed [DATA_WIDTH-1:0] v;
      logic                         err;
      v = $signed(imm);
      case (imm_fmt_e'(fmt))
         FMT_R:        err = 1'b0;
         FMT_I, FMT_S: err = (v < IMM_I_MIN) || (v > IMM_I_MAX);
         FMT_B:        err = (v < IMM_B_MIN) || (v > IMM_B_MAX) || imm[0];
         FMT_U:        err = |imm[11:0];
         FMT_J:        err = (v < IMM_J_MIN) || (v > IMM_J_MAX) || imm[0];
         default:      err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational bit-scatter of register/funct fields and immediate into a RISC-V word.
// Illegal formats never reach the output because the top substitutes a NOP for them.
module instr_field_packer
   import instr_encoder_pkg::*;
(
   input  instr_fields_t          i_fields,
   output logic [DATA_WIDTH-1:0]  o_instr
);

   always_comb begin
      // NOTE: default assigned first so every path drives o_instr and no latch is inferred.
      o_instr = NOP_INSTR;
      case (imm_fmt_e'(i_fields.fmt))
         FMT_R: o_instr = {i_fields.funct7, i_fields.rs2, i_fields.rs1,
                           i_fields.funct3, i_fields.rd, i_fields.opcode};
         FMT_I: o_instr = {i_fields.imm[11:0], i_fields.rs1, i_fields.funct3,
                           i_fields.rd, i_fields.opcode};
         FMT_S: o_instr = {i_fields.imm[11:5], i_fields.rs2, i_fields.rs1,
                           i_fields.funct3, i_fields.imm[4:0], i_fields.opcode};
         FMT_B: o_instr = {i_fields.imm[12], i_fields.imm[10:5], i_fields.rs2,
                           i_fields.rs1, i_fields.funct3, i_fields.imm[4:1],
                           i_fields.imm[11], i_fields.opcode};
         FMT_U: o_instr = {i_fields.imm[31:12], i_fields.rd, i_fields.opcode};
         FMT_J: o_instr = {i_fields.imm[20], i_fields.imm[10:1], i_fields.imm[11],
                           i_fields.imm[19:12], i_fields.rd, i_fields.opcode};
         default: o_instr = NOP_INSTR;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready instruction encoder: stage 1 latches fields and the immediate check,
// stage 2 holds the packed word; an output-handshake counter supplies the IMEM word address.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear_i,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [2:0]            fmt_i,
   input  logic [6:0]            opcode_i,
   input  logic [4:0]            rd_i,
   input  logic [4:0]            rs1_i,
   input  logic [4:0]            rs2_i,
   input  logic [2:0]            funct3_i,
   input  logic [6:0]            funct7_i,
   input  logic [DATA_WIDTH-1:0] imm_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic                  err_o,
   output logic                  err_sticky_o,
   output logic                  wrap_o
);

   logic                  r_s1_valid;
   instr_fields_t         r_s1_fields;
   logic                  r_s1_err;
   logic                  r_s2_valid;
   logic [DATA_WIDTH-1:0] r_s2_instr;
   logic                  r_s2_err;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic                  r_err_sticky;
   logic                  r_wrap;

   instr_fields_t         w_in_fields;
   logic                  w_in_err;
   logic [DATA_WIDTH-1:0] w_packed;
   logic [DATA_WIDTH-1:0] w_s2_instr;
   logic                  w_s2_adv;
   logic                  w_s1_adv;
   logic                  w_out_fire;

   assign w_s2_adv   = !r_s2_valid || out_ready_i;
   assign w_s1_adv   = !r_s1_valid || w_s2_adv;
   assign w_out_fire = r_s2_valid && out_ready_i;
   // Held low while reset is asserted so a source never sees a beat accepted into a dead pipe.
   assign in_ready_o = rst_n && w_s1_adv;

   assign w_in_fields = '{fmt: fmt_i, opcode: opcode_i, rd: rd_i, rs1: rs1_i, rs2: rs2_i,
                          funct3: funct3_i, funct7: funct7_i, imm: imm_i};
   assign w_in_err    = imm_check_err(fmt_i, imm_i);

   instr_field_packer u_packer (
      .i_fields (r_s1_fields),
      .o_instr  (w_packed)
   );

   assign w_s2_instr = r_s1_err ? NOP_INSTR : w_packed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         r_s1_valid  <= 1'b0;
         r_s1_fields <= '0;
         r_s1_err    <= 1'b0;
      end else if (clear_i) begin
         r_s1_valid  <= 1'b0;
      end else if (w_s1_adv) begin
         r_s1_valid  <= in_valid_i;
         if (in_valid_i) begin
            r_s1_fields <= w_in_fields;
            r_s1_err    <= w_in_err;
         end
      end
   end

   // Stage 2 only loads when it may advance, which keeps the presented word stable under stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_instr <= '0;
         r_s2_err   <= 1'b0;
      end else if (clear_i) begin
         r_s2_valid <= 1'b0;
         r_s2_instr <= '0;
         r_s2_err   <= 1'b0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_instr <= w_s2_instr;
            r_s2_err   <= r_s1_err;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr       <= '0;
         r_err_sticky <= 1'b0;
         r_wrap       <= 1'b0;
      end else if (clear_i) begin
         r_addr       <= '0;
         r_err_sticky <= 1'b0;
         r_wrap       <= 1'b0;
      end else begin
         if (w_s2_adv && r_s1_valid && r_s1_err) begin
            r_err_sticky <= 1'b1;
         end
         if (w_out_fire) begin
            r_addr <= r_addr + ADDR_WIDTH'(1);
            if (r_addr == '1) begin
               r_wrap <= 1'b1;
            end
         end
      end
   end

   assign out_valid_o  = r_s2_valid;
   assign instr_o      = r_s2_instr;
   assign err_o        = r_s2_err;
   assign addr_o       = r_addr;
   assign err_sticky_o = r_err_sticky;
   assign wrap_o       = r_wrap;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: the driver pushes hand-computed expected words on
// acceptance, a negedge monitor pops and compares whenever the DUT presents a word.
module tb_instr_encoder;
   import instr_encoder_pkg::*;

   localparam int AW = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  clear_i;
   logic                  in_valid_i;
   logic                  in_ready_o;
   logic [2:0]            fmt_i;
   logic [6:0]            opcode_i;
   logic [4:0]            rd_i, rs1_i, rs2_i;
   logic [2:0]            funct3_i;
   logic [6:0]            funct7_i;
   logic [DATA_WIDTH-1:0] imm_i;
   logic                  out_valid_o;
   logic                  out_ready_i;
   logic [DATA_WIDTH-1:0] instr_o;
   logic [AW-1:0]         addr_o;
   logic                  err_o;
   logic                  err_sticky_o;
   logic                  wrap_o;

   instr_encoder #(.ADDR_WIDTH(AW)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (clear_i),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .fmt_i        (fmt_i),
      .opcode_i     (opcode_i),
      .rd_i         (rd_i),
      .rs1_i        (rs1_i),
      .rs2_i        (rs2_i),
      .funct3_i     (funct3_i),
      .funct7_i     (funct7_i),
      .imm_i        (imm_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .instr_o      (instr_o),
      .addr_o       (addr_o),
      .err_o        (err_o),
      .err_sticky_o (err_sticky_o),
      .wrap_o       (wrap_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]   instr;
      logic          err;
      logic [AW-1:0] addr;
      logic          sticky;
      logic          wrap;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   model_idx = 0;
   logic model_sticky = 1'b0;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_ALU   = 7'b0110011;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [31:0] instr, input logic err);
      exp_t e;
      model_sticky = model_sticky | err;
      e.instr  = err ? 32'h0000_0013 : instr;
      e.err    = err;
      e.addr   = AW'(model_idx);
      e.sticky = model_sticky;
      e.wrap   = (model_idx >= (1 << AW));
      model_idx++;
      sb_q.push_back(e);
   endtask

   task automatic flush_model();
      sb_q.delete();
      model_idx    = 0;
      model_sticky = 1'b0;
   endtask

   task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
      fmt_i = fmt; opcode_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
      funct3_i = f3; funct7_i = f7; imm_i = imm;
      in_valid_i = 1'b1;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm,
                       input logic [31:0] exp_instr, input logic exp_err);
      logic acc;
      acc = 1'b0;
      drive(fmt, op, rd, rs1, rs2, f3, f7, imm);
      for (int c = 0; c < 50 && !acc; c++) begin
         @(negedge clk);
         if (in_ready_o) acc = 1'b1;
         else @(posedge clk);
      end
      check("send_accept", 32'(acc), 32'd1);
      if (acc) begin
         push_exp(exp_instr, exp_err);
         @(posedge clk);
      end
      #1;
      in_valid_i = 1'b0;
   endtask

   task automatic wait_drain();
      for (int c = 0; c < 100 && sb_q.size() != 0; c++) @(posedge clk);
      #1;
      check("drain_empty", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic pulse_clear();
      clear_i = 1'b1;
      @(posedge clk);
      #1;
      clear_i    = 1'b0;
      in_valid_i = 1'b0;
      flush_model();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid_o) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_word: got instr %h addr %0d with empty scoreboard",
                        instr_o, addr_o);
            end else if (out_ready_i) begin
               e = sb_q.pop_front();
               check("instr",  instr_o,             e.instr);
               check("err",    32'(err_o),          32'(e.err));
               check("addr",   32'(addr_o),         32'(e.addr));
               check("sticky", 32'(err_sticky_o),   32'(e.sticky));
               check("wrap",   32'(wrap_o),         32'(e.wrap));
            end else begin
               e = sb_q[0];
               check("stall_instr", instr_o,        e.instr);
               check("stall_addr",  32'(addr_o),    32'(e.addr));
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin : stimulus
      int n;
      rst_n = 1'b0; clear_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
      fmt_i = '0; opcode_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0;
      funct3_i = '0; funct7_i = '0; imm_i = '0;
      #2;
      check("rst_in_ready",  32'(in_ready_o),   32'd0);
      check("rst_out_valid", 32'(out_valid_o),  32'd0);
      check("rst_instr",     instr_o,           32'd0);
      check("rst_addr",      32'(addr_o),       32'd0);
      check("rst_err",       32'(err_o),        32'd0);
      check("rst_sticky",    32'(err_sticky_o), 32'd0);
      check("rst_wrap",      32'(wrap_o),       32'd0);
      #21 rst_n = 1'b1;
      @(posedge clk); #1;
      check("in_ready_after_rst", 32'(in_ready_o), 32'd1);

      // First word with latency measurement: accepting edge counts as 1.
      send(FMT_I, OP_LOAD, 5'd1, 5'd2, 5'd0, 3'b010, 7'd0, -32'sd1, 32'hFFF12083, 1'b0);
      n = 1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (out_valid_o) break;
         @(posedge clk);
         n++;
      end
      check("latency", 32'(n), 32'd2);
      @(posedge clk); #1;

      // Directed vectors, back to back.
      send(FMT_S, OP_STORE, 5'd0, 5'd2, 5'd1, 3'b010, 7'd0, -32'sd2,  32'hFE112F23, 1'b0);
      send(FMT_B, OP_BR,    5'd0, 5'd1, 5'd2, 3'b000, 7'd0, -32'sd4,  32'hFE208EE3, 1'b0);
      send(FMT_B, OP_BR,    5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3,    32'h00000013, 1'b1);
      send(FMT_U, OP_LUI,   5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFFF000, 32'hFFFFF0B7, 1'b0);
      send(FMT_J, OP_JAL,   5'd1, 5'd0, 5'd0, 3'b000, 7'd0, -32'sd2,  32'hFFFFF0EF, 1'b0);
      send(FMT_I, OP_LOAD,  5'd1, 5'd2, 5'd0, 3'b010, 7'd0, 32'd2048, 32'h00000013, 1'b1);
      send(FMT_U, OP_LUI,   5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h800,  32'h00000013, 1'b1);
      send(FMT_R, OP_ALU,   5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'hDEADBEEF, 32'h002081B3, 1'b0);
      send(FMT_R, OP_ALU,   5'd3, 5'd1, 5'd2, 3'b000, 7'b0100000, 32'd5, 32'h402081B3, 1'b0);
      send(FMT_I, OP_LOAD,  5'd1, 5'd2, 5'd0, 3'b010, 7'd0, 32'd2047, 32'h7FF12083, 1'b0);
      send(FMT_I, OP_LOAD,  5'd1, 5'd2, 5'd0, 3'b010, 7'd0, -32'sd2048, 32'h80012083, 1'b0);
      send(FMT_I, OP_LOAD,  5'd1, 5'd2, 5'd0, 3'b010, 7'd0, -32'sd2049, 32'h00000013, 1'b1);
      send(FMT_B, OP_BR,    5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd4094, 32'h7E208FE3, 1'b0);
      send(FMT_B, OP_BR,    5'd0, 5'd1, 5'd2, 3'b000, 7'd0, -32'sd4096, 32'h80208063, 1'b0);
      send(FMT_B, OP_BR,    5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd4096, 32'h00000013, 1'b1);
      send(FMT_J, OP_JAL,   5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1048574, 32'h7FFFF0EF, 1'b0);
      send(FMT_J, OP_JAL,   5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1048576, 32'h00000013, 1'b1);
      send(FMT_J, OP_JAL,   5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3,    32'h00000013, 1'b1);
      send(3'd6,  OP_ALU,   5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0,    32'h00000013, 1'b1);
      send(3'd7,  OP_ALU,   5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0,    32'h00000013, 1'b1);
      send(FMT_U, OP_LUI,   5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
      wait_drain();

      // Empty clear so the following addresses start at 0.
      pulse_clear();
      @(negedge clk);
      check("clr0_addr",   32'(addr_o),       32'd0);
      check("clr0_sticky", 32'(err_sticky_o), 32'd0);
      check("clr0_wrap",   32'(wrap_o),       32'd0);
      @(posedge clk); #1;

      // Backpressure: two beats fill the pipe, a third must wait.
      out_ready_i = 1'b0;
      send(FMT_R, OP_ALU,  5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0, 32'h002081B3, 1'b0);
      send(FMT_I, OP_LOAD, 5'd1, 5'd2, 5'd0, 3'b010, 7'd0, -32'sd1, 32'hFFF12083, 1'b0);
      drive(FMT_S, OP_STORE, 5'd0, 5'd2, 5'd1, 3'b010, 7'd0, -32'sd2);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("bp_in_ready",  32'(in_ready_o),  32'd0);
         check("bp_out_valid", 32'(out_valid_o), 32'd1);
         @(posedge clk); #1;
      end
      out_ready_i = 1'b1;
      send(FMT_S, OP_STORE, 5'd0, 5'd2, 5'd1, 3'b010, 7'd0, -32'sd2, 32'hFE112F23, 1'b0);
      // Words 4 and 5 reach the top of the 2-bit address space and wrap.
      send(FMT_B, OP_BR,    5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3, 32'h00000013, 1'b1);
      send(FMT_U, OP_LUI,   5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFFF000, 32'hFFFFF0B7, 1'b0);
      wait_drain();
      check("wrap_set",   32'(wrap_o),       32'd1);
      check("sticky_set", 32'(err_sticky_o), 32'd1);

      // Clear with words in flight and a beat offered in the same cycle.
      @(posedge clk); #1;
      out_ready_i = 1'b0;
      send(FMT_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, -32'sd2, 32'hFFFFF0EF, 1'b0);
      drive(FMT_I, OP_LOAD, 5'd1, 5'd2, 5'd0, 3'b010, 7'd0, 32'd7);
      pulse_clear();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("clr_out_valid", 32'(out_valid_o),  32'd0);
         check("clr_addr",      32'(addr_o),       32'd0);
         check("clr_sticky",    32'(err_sticky_o), 32'd0);
         check("clr_wrap",      32'(wrap_o),       32'd0);
         @(posedge clk); #1;
      end
      out_ready_i = 1'b1;
      send(FMT_I, OP_LOAD, 5'd1, 5'd2, 5'd0, 3'b010, 7'd0, 32'd2047, 32'h7FF12083, 1'b0);
      wait_drain();

      // Asynchronous reset mid-stream.
      @(posedge clk); #1;
      out_ready_i = 1'b0;
      send(FMT_R, OP_ALU,  5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0, 32'h002081B3, 1'b0);
      send(FMT_B, OP_BR,   5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd1, 32'h00000013, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_out_valid", 32'(out_valid_o),  32'd0);
      check("arst_instr",     instr_o,           32'd0);
      check("arst_addr",      32'(addr_o),       32'd0);
      check("arst_err",       32'(err_o),        32'd0);
      check("arst_sticky",    32'(err_sticky_o), 32'd0);
      check("arst_wrap",      32'(wrap_o),       32'd0);
      check("arst_in_ready",  32'(in_ready_o),   32'd0);
      flush_model();
      #13 rst_n = 1'b1;
      @(posedge clk); #1;
      check("rerst_in_ready", 32'(in_ready_o), 32'd1);
      out_ready_i = 1'b1;
      send(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
      wait_drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
